fir_stream_sequencer: RTL and testbench

Wishbone-facing controller that sequences the user-project FIR datapath: it buffers input samples written by firmware, pulses ap_start, streams the samples over AXI-Stream to the FIR, collects outputs into a readback buffer, and reports done and cycle count. It sits in user_proj_example between the Wishbone slave decode and the FIR ss/sm/ap ports. It replaces the firmware's per-sample ap-handshake polling.

---
 rtl/fir_seq_pkg.sv | 8 +
 rtl/fir_stream_sequencer_if.sv | 8 +
 rtl/fir_seq_fifo.sv | 31 +++
 rtl/fir_stream_sequencer.sv | 125 ++++++++++++
 tb/tb_fir_stream_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: register map, CTRL bit positions and sequencer states for fir_stream_sequencer
package fir_seq_pkg;
  localparam logic [4:0] REG_CTRL = 5'h00, REG_LEN = 5'h04, REG_X = 5'h08, REG_Y = 5'h0C, REG_CYC = 5'h10;
  localparam logic [4:0] ADR_MASK = 5'h1C;
  localparam int CTRL_START = 0, CTRL_BUSY = 0, CTRL_DONE = 1, CTRL_IDLE = 2;
  localparam int CTRL_XFULL = 3, CTRL_YEMPTY = 4, CTRL_ERR = 5;
  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, DONE} state_e;
endpackage

// File: rtl/fir_stream_sequencer_if.sv
// fir_stream_sequencer_if: Wishbone slave bus between the address decode and the sequencer
interface fir_stream_sequencer_if #(parameter int DATA_W = 32);
  logic wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
  logic [4:0] wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i, wbs_dat_o;
  modport master(output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, input wbs_dat_o, wbs_ack_o);
  modport slave(input wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, output wbs_dat_o, wbs_ack_o);
endinterface

// File: rtl/fir_seq_fifo.sv
// fir_seq_fifo: show-ahead synchronous FIFO; callers never push when full or pop when empty
module fir_seq_fifo #(parameter int DATA_W = 32, parameter int DEPTH = 8) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign rdata_o = mem_q[rp_q];
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push_i);
      rp_q <= rp_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
endmodule

// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: Wishbone-driven FIR run sequencer with X/Y sample buffers.
// Define FIR_SEQ_CYCLE_CNT_EN to build the CYC run-length counter (otherwise CYC reads 0).
module fir_stream_sequencer
  import fir_seq_pkg::*;
#(parameter int DATA_W = 32, parameter int FIFO_DEPTH = 8, parameter int LEN_W = 10) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  fir_stream_sequencer_if.slave wb,
  output logic              ap_start_o,
  input  logic              ap_idle_i,
  output logic [LEN_W-1:0]  data_length_o,
  output logic              ss_tvalid_o,
  output logic [DATA_W-1:0] ss_tdata_o,
  output logic              ss_tlast_o,
  input  logic              ss_tready_i,
  input  logic              sm_tvalid_i,
  input  logic [DATA_W-1:0] sm_tdata_i,
  input  logic              sm_tlast_i,
  output logic              sm_tready_o,
  output logic              irq_o
);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic done_q, done_d, err_q, err_d, ack_q, ack_d;
  logic [DATA_W-1:0] dat_q, dat_d, x_rdata, y_rdata, cyc_val;
  logic [4:0] adr;
  logic [5:0] ctrl;
  logic we, req, x_full, x_empty, y_full, y_empty, x_push, y_pop, rd_ctrl, wr_start;
  logic run, ss_fire, sm_fire, err_set;
  assign adr = wb.wbs_adr_i & ADR_MASK;
  assign we = wb.wbs_we_i;
  assign req = wb.wbs_cyc_i && wb.wbs_stb_i && !ack_q;
  // X writes stall while full and Y reads stall while empty by withholding ack
  assign ack_d = req && !(we && adr == REG_X && x_full) && !(!we && adr == REG_Y && y_empty);
  assign x_push = ack_d && we && adr == REG_X;
  assign y_pop = ack_d && !we && adr == REG_Y;
  assign rd_ctrl = ack_d && !we && adr == REG_CTRL;
  assign wr_start = ack_d && we && adr == REG_CTRL && wb.wbs_dat_i[CTRL_START];
  assign run = state_q == STREAM || state_q == DRAIN;
  assign ss_tvalid_o = state_q == STREAM && !x_empty;
  assign ss_tdata_o = ss_tvalid_o ? x_rdata : '0;
  assign ss_tlast_o = ss_tvalid_o && in_cnt_q == len_q - 1'b1;
  assign sm_tready_o = run && !y_full && out_cnt_q != len_q;
  assign ss_fire = ss_tvalid_o && ss_tready_i;
  assign sm_fire = sm_tvalid_i && sm_tready_o;
  assign err_set = sm_fire && (sm_tlast_i != (out_cnt_q == len_q - 1'b1));
  assign ap_start_o = state_q == START;
  assign data_length_o = len_q;
  assign irq_o = done_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  fir_seq_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_x (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(x_push), .pop_i(ss_fire), .wdata_i(wb.wbs_dat_i),
    .rdata_o(x_rdata), .full_o(x_full), .empty_o(x_empty));
  fir_seq_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_y (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(sm_fire), .pop_i(y_pop), .wdata_i(sm_tdata_i),
    .rdata_o(y_rdata), .full_o(y_full), .empty_o(y_empty));
`ifdef FIR_SEQ_CYCLE_CNT_EN
  logic [DATA_W-1:0] cyc_q, cyc_d;
  assign cyc_d = ap_start_o ? DATA_W'(1) : (run && out_cnt_q != len_q && ~&cyc_q) ? cyc_q + 1'b1 : cyc_q;
  assign cyc_val = cyc_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) cyc_q <= '0;
    else cyc_q <= cyc_d;
`else
  assign cyc_val = '0;
`endif
  // status bits report a done/err event landing in the same cycle as the clearing read
  always_comb begin
    ctrl = '0;
    ctrl[CTRL_BUSY] = state_q != IDLE;
    ctrl[CTRL_DONE] = done_q || state_q == DONE;
    ctrl[CTRL_IDLE] = ap_idle_i;
    ctrl[CTRL_XFULL] = x_full;
    ctrl[CTRL_YEMPTY] = y_empty;
    ctrl[CTRL_ERR] = err_q || err_set;
  end
  always_comb begin
    dat_d = '0;
    if (ack_d && !we)
      dat_d = adr == REG_CTRL ? DATA_W'(ctrl) : adr == REG_LEN ? DATA_W'(len_q) :
              adr == REG_Y ? y_rdata : adr == REG_CYC ? cyc_val : '0;
  end
  always_comb begin
    state_d = state_q;
    in_cnt_d = in_cnt_q;
    out_cnt_d = out_cnt_q;
    len_d = (ack_d && we && adr == REG_LEN && state_q == IDLE) ? wb.wbs_dat_i[LEN_W-1:0] : len_q;
    done_d = rd_ctrl ? 1'b0 : state_q == DONE ? 1'b1 : done_q;
    err_d = rd_ctrl ? 1'b0 : err_set ? 1'b1 : err_q;
    if (ss_fire) in_cnt_d = in_cnt_q + 1'b1;
    if (sm_fire) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (wr_start) state_d = len_q == '0 ? DONE : ap_idle_i ? START : IDLE;
      START: begin
        state_d = STREAM;
        in_cnt_d = '0;
        out_cnt_d = '0;
      end
      STREAM: if (ss_fire && ss_tlast_o) state_d = DRAIN;
      DRAIN: if (out_cnt_q == len_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      len_q <= '0;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q <= done_d;
      err_q <= err_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb_fir_stream_sequencer: random-sample runs through a 3-tap, 3-cycle-latency FIR model
// with golden outputs computed from the samples firmware pushed.
module tb_fir_stream_sequencer;
  import fir_seq_pkg::*;
  localparam int DW = 32, LW = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic ap_start, ap_idle = 1'b1, irq;
  logic [LW-1:0] dlen;
  logic ss_tvalid, ss_tlast, ss_tready = 1'b0;
  logic [DW-1:0] ss_tdata;
  logic sm_tvalid = 1'b0, sm_tlast = 1'b0, sm_tready;
  logic [DW-1:0] sm_tdata = '0;
  int n_tests = 0, n_fail = 0, cyc_n = 0;
  bit fir_hold = 1'b0;
  int last_at = 0, run_len = 0, in_beats = 0, out_beats = 0, n_start = 0, t_start = 0, t_last = 0;
  logic [DW-1:0] xs[$], q_d[$], sent[$];
  int q_t[$];
  bit q_l[$];

  fir_stream_sequencer_if #(.DATA_W(DW)) wb ();
  fir_stream_sequencer #(.DATA_W(DW), .FIFO_DEPTH(8), .LEN_W(LW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb), .ap_start_o(ap_start), .ap_idle_i(ap_idle),
    .data_length_o(dlen), .ss_tvalid_o(ss_tvalid), .ss_tdata_o(ss_tdata), .ss_tlast_o(ss_tlast),
    .ss_tready_i(ss_tready), .sm_tvalid_i(sm_tvalid), .sm_tdata_i(sm_tdata), .sm_tlast_i(sm_tlast),
    .sm_tready_o(sm_tready), .irq_o(irq));

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // y[n] = x[n] + 2*x[n-1] + 3*x[n-2], modulo 2^32
  function automatic logic [DW-1:0] fir_ref(input logic [DW-1:0] x[$], input int n);
    fir_ref = x[n] + (n >= 1 ? x[n-1] * 32'd2 : '0) + (n >= 2 ? x[n-2] * 32'd3 : '0);
  endfunction

  // FIR device model: handshakes are decided at the negedge and happen at the next posedge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q_d.delete(); q_t.delete(); q_l.delete();
      ap_idle = 1'b1; sm_tvalid = 1'b0; ss_tready = 1'b0;
    end else begin
      if (ap_start) begin
        n_start++; ap_idle = 1'b0; run_len = int'(dlen);
        in_beats = 0; out_beats = 0; xs.delete(); t_start = cyc_n;
      end
      ss_tready = !fir_hold && $urandom_range(3) != 0;
      sm_tvalid = q_d.size() > 0 && q_t[0] <= cyc_n;
      if (sm_tvalid) begin
        sm_tdata = q_d[0];
        sm_tlast = q_l[0];
      end
      if (ss_tvalid && ss_tready) begin
        xs.push_back(ss_tdata);
        in_beats++;
        check("ss_tlast", 32'(ss_tlast), 32'(in_beats == run_len));
        q_d.push_back(fir_ref(xs, in_beats - 1));
        q_t.push_back(cyc_n + 3);
        q_l.push_back(in_beats == (last_at != 0 ? last_at : run_len));
      end
      if (sm_tvalid && sm_tready) begin
        void'(q_d.pop_front()); void'(q_t.pop_front()); void'(q_l.pop_front());
        out_beats++;
        t_last = cyc_n;
        if (out_beats == run_len) ap_idle = 1'b1;
      end
    end
  end

  task automatic wb_xfer(input bit we, input logic [4:0] adr, input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    bit ok = 1'b0;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we; wb.wbs_adr_i = adr; wb.wbs_dat_i = wd;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = wb.wbs_ack_o;
    end
    rd = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    if (!ok) check("wb_ack_timeout", 32'(ok), 1);
  endtask

  task automatic wb_wr(input logic [4:0] adr, input logic [DW-1:0] d);
    logic [DW-1:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_rd(input logic [4:0] adr, output logic [DW-1:0] d);
    wb_xfer(1'b0, adr, '0, d);
  endtask

  task automatic push(input logic [DW-1:0] d);
    wb_wr(REG_X, d);
    sent.push_back(d);
  endtask

  task automatic drain(input int from, input int n, input string tag);
    logic [DW-1:0] rd;
    for (int i = from; i < n; i++) begin
      wb_rd(REG_Y, rd);
      check(tag, rd, fir_ref(sent, i));
    end
  endtask

  task automatic check_cyc(input string tag);
    logic [DW-1:0] rd;
    wb_rd(REG_CYC, rd);
`ifdef FIR_SEQ_CYCLE_CNT_EN
    check(tag, rd, 32'(t_last - t_start + 1));
`else
    check(tag, rd, 0);
`endif
  endtask

  initial begin
    logic [DW-1:0] rd;
    int t_rel, t_ack;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ap_start", 32'(ap_start), 0);
    check("rst_ss_tvalid", 32'(ss_tvalid), 0);
    check("rst_irq", 32'(irq), 0);
    wb_rd(REG_CTRL, rd); check("rst_ctrl", rd, 32'h14);
    wb_rd(REG_CYC, rd); check("rst_cyc", rd, 0);
    // 64-sample run with busy-time LEN write and start ignored
    wb_wr(REG_LEN, 64); wb_wr(REG_CTRL, 1); sent.delete();
    wb_wr(REG_LEN, 5); wb_rd(REG_LEN, rd); check("len_busy", rd, 64);
    check("data_length", 32'(dlen), 64);
    wb_wr(REG_CTRL, 1);
    for (int i = 1; i <= 64; i++) push(DW'(i));
    drain(0, 64, "y_main");
    repeat (2) @(negedge clk);
    check("main_irq", 32'(irq), 1);
    check("main_starts", n_start, 1);
    check_cyc("main_cyc");
    wb_rd(REG_CTRL, rd); check("main_ctrl", rd, 32'h16);
    check("irq_cleared", 32'(irq), 0);
    wb_rd(REG_CTRL, rd); check("ctrl_after_clear", rd, 32'h14);
    // X full: ninth write stalls until the stream consumes a sample
    fir_hold = 1'b1; wb_wr(REG_LEN, 9); wb_wr(REG_CTRL, 1); sent.delete();
    for (int i = 0; i < 8; i++) push($urandom);
    wb_rd(REG_CTRL, rd); check("ctrl_xfull", rd, 32'h19);
    fork
      begin push($urandom); t_ack = cyc_n; end
      begin repeat (12) @(negedge clk); t_rel = cyc_n; fir_hold = 1'b0; end
    join
    check("x_full_stall", 32'(t_ack > t_rel), 1);
    drain(0, 9, "y_xfull");
    wb_rd(REG_CTRL, rd); check("xfull_ctrl", rd, 32'h16);
    // Y empty: read stalls until the first output beat lands
    wb_wr(REG_LEN, 4); sent.delete(); fir_hold = 1'b1;
    for (int i = 0; i < 4; i++) push($urandom);
    wb_wr(REG_CTRL, 1);
    fork
      begin wb_rd(REG_Y, rd); t_ack = cyc_n; end
      begin repeat (12) @(negedge clk); t_rel = cyc_n; fir_hold = 1'b0; end
    join
    check("y_empty_stall", 32'(t_ack > t_rel), 1);
    check("y_first", rd, fir_ref(sent, 0));
    drain(1, 4, "y_yempty");
    wb_rd(REG_CTRL, rd); check("yempty_ctrl", rd, 32'h16);
    // LEN=0 completes without ap_start
    wb_wr(REG_LEN, 0); wb_wr(REG_CTRL, 1);
    @(negedge clk);
    check("len0_irq", 32'(irq), 1);
    wb_rd(REG_CTRL, rd); check("len0_ctrl", rd, 32'h16);
    check("len0_no_start", n_start, 3);
    // early tlast on beat 10 of 16
    last_at = 10; wb_wr(REG_LEN, 16); wb_wr(REG_CTRL, 1); sent.delete();
    for (int i = 0; i < 16; i++) push($urandom);
    drain(0, 16, "y_err");
    check_cyc("err_cyc");
    wb_rd(REG_CTRL, rd); check("err_ctrl", rd, 32'h36);
    wb_rd(REG_CTRL, rd); check("err_cleared", rd, 32'h14);
    last_at = 0;
    // asynchronous reset mid-STREAM
    fir_hold = 1'b1; wb_wr(REG_LEN, 8); wb_wr(REG_CTRL, 1); sent.delete();
    for (int i = 0; i < 3; i++) push($urandom);
    @(negedge clk);
    check("pre_rst_tvalid", 32'(ss_tvalid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ap_start", 32'(ap_start), 0);
    check("arst_ss_tvalid", 32'(ss_tvalid), 0);
    check("arst_sm_tready", 32'(sm_tready), 0);
    check("arst_len", 32'(dlen), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; fir_hold = 1'b0;
    wb_rd(REG_CTRL, rd); check("arst_ctrl", rd, 32'h14);
    wb_rd(REG_CYC, rd); check("arst_cyc", rd, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
